// File: rtl/id_stage_pipe.sv
// ============================================================================
// Module   : id_stage_pipe
// Brief    : Pipelined RV32I decode stage with register file, immediate gen,
//            load-use interlock, flush and an ID/EX valid/ready output register.
//            Optional macro ID_WB_BYPASS_EN: same-cycle writeback write-through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int PCW  = 32,
    parameter int CNTW = 16,
    localparam int RW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PCW-1:0]  in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PCW-1:0]  out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_f3,
    output logic [6:0]      out_f7,
    output logic [RW-1:0]   out_rd,
    output logic [XLEN-1:0] out_r1,
    output logic [XLEN-1:0] out_r2,
    output logic [XLEN-1:0] out_imm,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [CNTW-1:0] bubble_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic [PCW-1:0]  pc_q;
    logic [6:0]      opcode_q;
    logic [2:0]      f3_q;
    logic [6:0]      f7_q;
    logic [RW-1:0]   rd_q;
    logic [XLEN-1:0] r1_q, r2_q, imm_q;
    logic [CNTW-1:0] cnt_q;

    logic [6:0]        w_opc;
    logic [RW-1:0]     w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0]   w_r1, w_r2, w_imm;
    logic signed [31:0] w_imm32;
    logic              w_no_rs2, w_hz, w_adv, w_xfer;

    assign w_opc = in_inst[6:0];
    assign w_rs1 = in_inst[15 +: RW];
    assign w_rs2 = in_inst[20 +: RW];
    assign w_rd  = in_inst[7 +: RW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        w_r1 = (w_rs1 == '0) ? '0 : rf_q[w_rs1];
        w_r2 = (w_rs2 == '0) ? '0 : rf_q[w_rs2];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && (wb_rd != '0) && (wb_rd == w_rs1)) w_r1 = wb_data;
        if (wb_en && (wb_rd != '0) && (wb_rd == w_rs2)) w_r2 = wb_data;
`endif
    end

    always_comb begin
        case (w_opc)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYS:
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            OP_STORE:
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            OP_BRANCH:
                w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                w_imm32 = {in_inst[31:12], 12'b0};
            OP_JAL:
                w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    // Size cast of a signed operand sign-extends for XLEN=64
    assign w_imm = XLEN'(w_imm32);

    // I/U/J formats carry no rs2 field, so bits [24:20] must not cause a stall
    assign w_no_rs2 = (w_opc == OP_LOAD) || (w_opc == OP_IMM) || (w_opc == OP_JALR) ||
                      (w_opc == OP_SYS)  || (w_opc == OP_LUI) || (w_opc == OP_AUIPC) ||
                      (w_opc == OP_JAL);

    assign w_hz = (state_q == ST_FULL) && (opcode_q == OP_LOAD) && (rd_q != '0) &&
                  in_valid && ((w_rs1 == rd_q) || ((w_rs2 == rd_q) && !w_no_rs2));

    assign w_adv  = (state_q == ST_EMPTY) || out_ready;
    assign w_xfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (w_adv) begin
            state_d = w_xfer ? ST_FULL : ST_EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        in_ready  = w_adv && !w_hz && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            opcode_q <= '0;
            f3_q     <= '0;
            f7_q     <= '0;
            rd_q     <= '0;
            r1_q     <= '0;
            r2_q     <= '0;
            imm_q    <= '0;
        end else if (w_xfer) begin
            pc_q     <= in_pc;
            opcode_q <= w_opc;
            f3_q     <= in_inst[14:12];
            f7_q     <= in_inst[31:25];
            rd_q     <= w_rd;
            r1_q     <= w_r1;
            r2_q     <= w_r2;
            imm_q    <= w_imm;
        end
    end

    // A flush in the same cycle as a hazard suppresses the bubble count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!flush && w_adv && w_hz && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_pc     = pc_q;
    assign out_opcode = opcode_q;
    assign out_f3     = f3_q;
    assign out_f7     = f7_q;
    assign out_rd     = rd_q;
    assign out_r1     = r1_q;
    assign out_r2     = r2_q;
    assign out_imm    = imm_q;
    assign bubble_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
// ============================================================================
// Module   : tb_id_stage_pipe
// Brief    : Self-checking bench for id_stage_pipe (vector table, directed
//            corner sequences, randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_pipe;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int PCW  = 32;
    localparam int CNTW = 16;
    localparam int RW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [31:0]     in_inst;
    logic [PCW-1:0]  in_pc;
    logic            out_valid, out_ready;
    logic [PCW-1:0]  out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_f3;
    logic [6:0]      out_f7;
    logic [RW-1:0]   out_rd;
    logic [XLEN-1:0] out_r1, out_r2, out_imm;
    logic            wb_en;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [CNTW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NREG(NREG), .PCW(PCW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_f3(out_f3), .out_f7(out_f7), .out_rd(out_rd),
        .out_r1(out_r1), .out_r2(out_r2), .out_imm(out_imm),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .bubble_cnt(bubble_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [XLEN-1:0] m_rf [NREG];
    bit              m_valid;
    logic [31:0]     m_inst;
    logic [PCW-1:0]  m_pc;
    logic [XLEN-1:0] m_r1, m_r2;
    int              m_cnt;
    bit              m_xfer;

    function automatic logic [31:0] ref_imm(input logic [31:0] x);
        int v;
        case (x[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = int'($signed(x[31:20]));
            7'h23:        v = int'($signed({x[31:25], x[11:7]}));
            7'h63:        v = int'($signed({x[31], x[7], x[30:25], x[11:8]})) * 2;
            7'h37, 7'h17: v = int'(x & 32'hFFFF_F000);
            7'h6F:        v = int'($signed({x[31], x[19:12], x[20], x[30:21]})) * 2;
            default:      v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit no_rs2(input logic [6:0] op);
        return op inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h37, 7'h17, 7'h6F};
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return '0;
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_data;
`endif
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        m_valid = 0; m_inst = '0; m_pc = '0; m_r1 = '0; m_r2 = '0; m_cnt = 0; m_xfer = 0;
    endtask

    // Compare current DUT state with the model, then step the model over the edge
    task automatic model_step();
        bit hz, rdy;
        logic [4:0] prd;
        logic [XLEN-1:0] v1, v2;
        prd = m_inst[11:7];
        hz  = m_valid && (m_inst[6:0] == 7'h03) && (prd != 0) && in_valid &&
              ((in_inst[19:15] == prd) || ((in_inst[24:20] == prd) && !no_rs2(in_inst[6:0])));
        rdy = (!m_valid || out_ready) && !hz && !flush;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
        if (m_valid) begin
            chk("out_pc", 64'(out_pc), 64'(m_pc));
            chk("out_opcode", 64'(out_opcode), 64'(m_inst[6:0]));
            chk("out_f3", 64'(out_f3), 64'(m_inst[14:12]));
            chk("out_f7", 64'(out_f7), 64'(m_inst[31:25]));
            chk("out_rd", 64'(out_rd), 64'(m_inst[11:7]));
            chk("out_r1", 64'(out_r1), 64'(m_r1));
            chk("out_r2", 64'(out_r2), 64'(m_r2));
            chk("out_imm", 64'(out_imm), 64'(ref_imm(m_inst)));
        end
        v1 = m_read(in_inst[19:15]);
        v2 = m_read(in_inst[24:20]);
        m_xfer = in_valid && rdy;
        if (flush) begin
            m_valid = 0;
        end else if (!m_valid || out_ready) begin
            if (m_xfer) begin
                m_valid = 1; m_inst = in_inst; m_pc = in_pc; m_r1 = v1; m_r2 = v2;
            end else begin
                m_valid = 0;
            end
            if (hz && m_cnt < 65535) m_cnt++;
        end
        if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    endtask

    task automatic cyc();
        #4;
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0] ops [11];
        logic [31:0] x;
        logic [2:0] a, b, c;
        ops = '{7'h03, 7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        x = $urandom;
        a = 3'($urandom_range(0, 7));
        b = 3'($urandom_range(0, 7));
        c = 3'($urandom_range(0, 7));
        x[6:0]   = ops[$urandom_range(0, 10)];
        x[11:7]  = {2'b00, c};
        x[19:15] = {2'b00, a};
        x[24:20] = {2'b00, b};
        return x;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{32'hFFF2_8313, 32'hFFFF_FFFF};
        vecs[1] = '{32'hFE11_2E23, 32'hFFFF_FFFC};
        vecs[2] = '{32'hFE00_0CE3, 32'hFFFF_FFF8};
        vecs[3] = '{32'h1234_50B7, 32'h1234_5000};
        vecs[4] = '{32'h0010_00EF, 32'h0000_0800};
        vecs[5] = '{32'h0000_0033, 32'h0000_0000};
        vecs[6] = '{32'h7FF0_0093, 32'h0000_07FF};
        vecs[7] = '{32'h8000_0037, 32'h8000_0000};

        rst_n = 0; in_valid = 0; in_inst = '0; in_pc = '0; out_ready = 1;
        wb_en = 0; wb_rd = '0; wb_data = '0; flush = 0;
        model_reset();
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_r1", 64'(out_r1), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // Writeback then dependent decode
        wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        cyc();
        wb_en = 0;
        in_valid = 1; in_inst = 32'hFFF2_8313; in_pc = 32'h100;
        #1 chk("t1_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 0;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_r1", 64'(out_r1), 64'hDEAD_BEEF);
        chk("t1_out_imm", 64'(out_imm), 64'hFFFF_FFFF);
        chk("t1_out_rd", 64'(out_rd), 64'd6);

        // Immediate vector table
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_inst = vecs[i].inst; in_pc = 32'h200 + 32'(i * 4);
            cyc();
            chk("vec_imm", 64'(out_imm), 64'(vecs[i].imm));
            chk("vec_pc", 64'(out_pc), 64'(32'h200 + 32'(i * 4)));
        end
        in_valid = 0;
        cyc();

        // Load-use interlock
        in_valid = 1; in_inst = 32'h0001_2383; in_pc = 32'h280;
        cyc();
        in_inst = 32'h0033_8433; in_pc = 32'h284;
        #1 chk("t3_stall", 64'(in_ready), 64'd0);
        cyc();
        chk("t3_bubble", 64'(out_valid), 64'd0);
        chk("t3_cnt", 64'(bubble_cnt), 64'd1);
        #1 chk("t3_resume", 64'(in_ready), 64'd1);
        cyc();
        chk("t3_add_valid", 64'(out_valid), 64'd1);
        chk("t3_add_rd", 64'(out_rd), 64'd8);

        // Back-pressure holds the output register
        out_ready = 0; in_inst = 32'h7FF0_0093; in_pc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_in_ready", 64'(in_ready), 64'd0);
            cyc();
            chk("t4_hold_pc", 64'(out_pc), 64'h284);
            chk("t4_hold_rd", 64'(out_rd), 64'd8);
        end
        out_ready = 1;
        #1 chk("t4_release", 64'(in_ready), 64'd1);
        cyc();
        chk("t4_next_pc", 64'(out_pc), 64'h300);

        // Flush with a valid output and a pending input
        in_inst = 32'h0000_0593; in_pc = 32'h400; flush = 1;
        #1 chk("t5_in_ready", 64'(in_ready), 64'd0);
        cyc();
        flush = 0;
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_cnt", 64'(bubble_cnt), 64'd1);
        cyc();
        chk("t5_accept_pc", 64'(out_pc), 64'h400);

        // Flush and hazard together: no bubble counted
        in_inst = 32'h0001_2383; in_pc = 32'h480;
        cyc();
        in_inst = 32'h0033_8433; in_pc = 32'h484; flush = 1;
        cyc();
        flush = 0;
        chk("t5b_cnt", 64'(bubble_cnt), 64'd1);
        cyc();
        chk("t5b_pc", 64'(out_pc), 64'h484);

        // Same-cycle writeback and x0 protection
        in_inst = 32'h0004_8513; in_pc = 32'h500;
        wb_en = 1; wb_rd = 5'd9; wb_data = 32'h55;
        cyc();
`ifdef ID_WB_BYPASS_EN
        chk("t6_bypass_r1", 64'(out_r1), 64'h55);
`else
        chk("t6_old_r1", 64'(out_r1), 64'h0);
`endif
        in_inst = 32'h0000_0593; in_pc = 32'h504;
        wb_rd = 5'd0; wb_data = 32'hFFFF;
        cyc();
        chk("t6_x0_r1", 64'(out_r1), 64'h0);
        wb_en = 0;
        in_inst = 32'h0004_8513; in_pc = 32'h508;
        cyc();
        chk("t6_x9_r1", 64'(out_r1), 64'h55);
        in_valid = 0;
        cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            if (!in_valid || m_xfer) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_inst  = gen_inst();
                in_pc    = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
